// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional illegal-op check enabled by defining ALU_OPCHK_EN (adds rsp_err).
`timescale 1ns/1ps

module alu_rr_arbiter #(
    parameter int DATA_W = 4,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_ovf
`ifdef ALU_OPCHK_EN
    ,
    output logic              rsp_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              ptr;
    logic              any_valid;
    logic              grant_id;
    logic              accept;
    logic              illegal;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [CTRL_W-1:0] sel_op;

    // Contention resolves to the pointer; a lone requester always wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ptr : req1_valid;
        accept    = (state == ST_IDLE) && any_valid;
        sel_a     = grant_id ? req1_a  : req0_a;
        sel_b     = grant_id ? req1_b  : req0_b;
        sel_op    = grant_id ? req1_op : req0_op;
    end

`ifdef ALU_OPCHK_EN
    assign illegal = (sel_op > CTRL_W'(4'b1011));
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = accept && !grant_id;
                req1_ready = accept &&  grant_id;
                if (accept) state_nxt = illegal ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
`ifdef ALU_OPCHK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                ptr    <= ~grant_id;
                rsp_id <= grant_id;
                if (!illegal) begin
                    alu_a    <= sel_a;
                    alu_b    <= sel_b;
                    alu_ctrl <= sel_op;
                end else begin
                    // Rejected op answers directly without touching the ALU.
                    rsp_valid  <= 1'b1;
                    rsp_result <= '0;
                    rsp_carry  <= 1'b0;
                    rsp_ovf    <= 1'b0;
`ifdef ALU_OPCHK_EN
                    rsp_err    <= 1'b1;
`endif
                end
            end
            if (state == ST_EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_ovf    <= alu_ovf;
`ifdef ALU_OPCHK_EN
                rsp_err    <= 1'b0;
`endif
            end
            if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a behavioural 4-bit ALU attached.
// Define ALU_OPCHK_EN to also exercise the illegal-op path.
`timescale 1ns/1ps

module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic [3:0] alu_a, alu_b, alu_ctrl, alu_result;
    logic       alu_carry, alu_ovf;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
    logic [3:0] rsp_result;
`ifdef ALU_OPCHK_EN
    logic       rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       id;
        logic [3:0] res;
        logic       c;
        logic       v;
        logic       e;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_rr_arbiter #(.DATA_W(4), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
`ifdef ALU_OPCHK_EN
        ,
        .rsp_err(rsp_err)
`endif
    );

    // External ALU: add, sub, or, and, xor; other codes give zero.
    logic [4:0] sum;
    always_comb begin
        sum        = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_ctrl)
            4'b0000: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[3:0];
                alu_carry  = sum[4];
                alu_ovf    = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
            end
            4'b0001: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result = sum[3:0];
                alu_carry  = sum[4];
                alu_ovf    = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
            end
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a & alu_b;
            4'b1000: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [3:0] res, input logic c,
                        input logic v, input logic e);
        exp_t x;
        x.id = id; x.res = res; x.c = c; x.v = v; x.e = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d result=%0h want none", rsp_id, rsp_result);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("rsp_id",     32'(rsp_id),     32'(x.id));
                chk("rsp_result", 32'(rsp_result), 32'(x.res));
                chk("rsp_carry",  32'(rsp_carry),  32'(x.c));
                chk("rsp_ovf",    32'(rsp_ovf),    32'(x.v));
`ifdef ALU_OPCHK_EN
                chk("rsp_err",    32'(rsp_err),    32'(x.e));
`endif
            end
        end
    end

    // Waits for the given requester's ready, then drops its valid after the accept edge.
    task automatic accept_wait(input int id);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
        end
        chk($sformatf("accept_req%0d", id), 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic issue1(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] op);
        if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        accept_wait(id);
    endtask

    // Holds both requesters valid until n commands have been accepted.
    task automatic run_both(input int n);
        int cnt = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 200 && cnt < n; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
                cnt++;
            end
        end
        chk("both_accepts", 32'(cnt), 32'(n));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_alu_a",      32'(alu_a),      0);
        chk("rst_alu_b",      32'(alu_b),      0);
        chk("rst_alu_ctrl",   32'(alu_ctrl),   0);
        chk("rst_rsp_valid",  32'(rsp_valid),  0);
        chk("rst_rsp_id",     32'(rsp_id),     0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_carry",  32'(rsp_carry),  0);
        chk("rst_rsp_ovf",    32'(rsp_ovf),    0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: lone req0 add, latency check
        push(0, 4'd7, 0, 0, 0);
        issue1(0, 4'd3, 4'd4, 4'b0000);
        @(negedge clk); chk("lat_exec", 32'(rsp_valid), 0);
        @(negedge clk); chk("lat_resp", 32'(rsp_valid), 1);
        drain();

        // 3: back-pressure while req1 waits (pointer now 1, req0 lone)
        rsp_ready = 1'b0;
        push(0, 4'd7, 0, 0, 0);
        push(1, 4'd0, 1, 0, 0);
        issue1(0, 4'd3, 4'd6, 4'b0110);
        req1_a = 4'hF; req1_b = 4'h1; req1_op = 4'b0000; req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(rsp_valid),  1);
            chk("bp_result", 32'(rsp_result), 7);
            chk("bp_id",     32'(rsp_id),     0);
            chk("bp_ready0", 32'(req0_ready), 0);
            chk("bp_ready1", 32'(req1_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        accept_wait(1);
        drain();

        // 2: simultaneous requests from reset pointer
        do_reset();
        req0_a = 4'd5; req0_b = 4'd7; req0_op = 4'b0001;
        req1_a = 4'd5; req1_b = 4'd7; req1_op = 4'b0001;
        push(0, 4'b1110, 0, 0, 0);
        push(1, 4'b1110, 0, 0, 0);
        run_both(2);
        drain();

        // 4: continuous contention alternates
        do_reset();
        req0_a = 4'd3; req0_b = 4'd6; req0_op = 4'b0111;
        req1_a = 4'd3; req1_b = 4'd6; req1_op = 4'b1000;
        push(0, 4'd2, 0, 0, 0);
        push(1, 4'd5, 0, 0, 0);
        push(0, 4'd2, 0, 0, 0);
        push(1, 4'd5, 0, 0, 0);
        run_both(4);
        drain();

        // 5: reset in EXEC drops the command and restores the pointer
        issue1(0, 4'd9, 4'd2, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_alu_a",     32'(alu_a),     0);
        chk("mid_alu_b",     32'(alu_b),     0);
        chk("mid_alu_ctrl",  32'(alu_ctrl),  0);
        chk("mid_rsp_id",    32'(rsp_id),    0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        req0_a = 4'd7; req0_b = 4'd1; req0_op = 4'b0000;
        req1_a = 4'd7; req1_b = 4'd1; req1_op = 4'b0001;
        push(0, 4'd8, 0, 1, 0);
        push(1, 4'd6, 1, 0, 0);
        run_both(2);
        drain();

`ifdef ALU_OPCHK_EN
        // 6: illegal op answers next cycle and leaves the ALU inputs alone
        push(0, 4'd0, 0, 0, 1);
        issue1(0, 4'd3, 4'd4, 4'b1101);
        @(negedge clk);
        chk("ill_fast_valid", 32'(rsp_valid), 1);
        chk("ill_alu_ctrl",   32'(alu_ctrl),  32'(4'b0001));
        chk("ill_alu_a",      32'(alu_a),     7);
        chk("ill_alu_b",      32'(alu_b),     1);
        drain();
`endif

        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
